// File: rtl/ftrace_pkg.sv
// Shared encodings for the function-call trace buffer: RISC-V jump opcodes,
// link registers, record kinds and the per-event payload layout.
package ftrace_pkg;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;

  typedef enum logic {
    KIND_CALL = 1'b0,
    KIND_RET  = 1'b1
  } ftrace_kind_e;

  // Depth is appended by the buffer, whose counter width is a parameter.
  typedef struct packed {
    ftrace_kind_e kind;
    logic [31:0]  pc;
    logic [31:0]  target;
  } ftrace_ev_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

endpackage

// File: rtl/ftrace_classify.sv
// Per-lane combinational call/return classifier for one retiring instruction.
module ftrace_classify
  import ftrace_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] inst,
  output logic        is_call,
  output logic        is_ret
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       call_match;
  logic       ret_match;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign unused_inst_bits = ^{inst[31:20], inst[14:12]};

  assign call_match = ((opcode == OP_JAL) || (opcode == OP_JALR)) && is_link(rd);
  assign ret_match  = (opcode == OP_JALR) && (rd == 5'd0) && is_link(rs1);

  // A JALR that both links and returns through a link register is a call.
  assign is_call = valid && call_match;
  assign is_ret  = valid && ret_match && !call_match;

endmodule

// File: rtl/ftrace_buffer.sv
// Multi-lane ftrace buffer: classifies retired jumps, tracks call depth and
// queues records for a valid/ready consumer, counting drops on overflow.
module ftrace_buffer
  import ftrace_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic [NUM_CH-1:0]      ret_valid,
  input  logic [NUM_CH*32-1:0]   ret_pc,
  input  logic [NUM_CH*32-1:0]   ret_nextpc,
  input  logic [NUM_CH*32-1:0]   ret_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_kind,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_target,
  output logic [DEPTH_W-1:0]     out_depth,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    ftrace_ev_t         ev;
    logic [DEPTH_W-1:0] depth;
  } rec_t;

  function automatic logic [DEPTH_W-1:0] depth_inc(input logic [DEPTH_W-1:0] d);
    return (&d) ? d : d + DEPTH_W'(1);
  endfunction

  function automatic logic [DEPTH_W-1:0] depth_dec(input logic [DEPTH_W-1:0] d);
    return (d == '0) ? d : d - DEPTH_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  rec_t               mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               ovf_q, ovf_d;

  logic [NUM_CH-1:0]  is_call;
  logic [NUM_CH-1:0]  is_ret;
  logic [NUM_CH-1:0]  we;
  logic [AW-1:0]      widx [NUM_CH];
  rec_t               wrec [NUM_CH];
  logic [PW-1:0]      count, free, n_push, wpos;
  logic [CNT_W-1:0]   n_drop;
  logic               pop;
  rec_t               head;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    ftrace_classify u_classify (
      .valid   (ret_valid[g] & trace_en),
      .inst    (ret_inst[g*32 +: 32]),
      .is_call (is_call[g]),
      .is_ret  (is_ret[g])
    );
  end

  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign pop       = out_valid & out_ready;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign free      = PW'(DEPTH) - count + PW'(pop);

  // Lanes are walked oldest first so lane 1 sees lane 0's depth update and
  // the youngest events are the ones that lose out when space runs short.
  always_comb begin
    depth_d = depth_q;
    n_push  = '0;
    n_drop  = '0;
    wpos    = wr_ptr_q;
    we      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      widx[i] = '0;
      wrec[i] = '0;
      if (is_call[i] || is_ret[i]) begin
        wrec[i].ev.kind   = is_call[i] ? KIND_CALL : KIND_RET;
        wrec[i].ev.pc     = ret_pc[i*32 +: 32];
        wrec[i].ev.target = ret_nextpc[i*32 +: 32];
        if (is_call[i]) begin
          wrec[i].depth = depth_d;
          depth_d       = depth_inc(depth_d);
        end else begin
          depth_d       = depth_dec(depth_d);
          wrec[i].depth = depth_d;
        end
        if (n_push < free) begin
          wpos    = wr_ptr_q + n_push;
          widx[i] = wpos[AW-1:0];
          we[i]   = 1'b1;
          n_push  = n_push + PW'(1);
        end else begin
          n_drop  = n_drop + CNT_W'(1);
        end
      end
    end
    wr_ptr_d = wr_ptr_q + n_push;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    drop_d   = cnt_add(drop_q, n_drop);
    ovf_d    = ovf_q | (n_drop != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      depth_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      depth_q  <= depth_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the head fields are masked by out_valid instead.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (we[i]) mem_q[widx[i]] <= wrec[i];
    end
  end

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign out_kind   = out_valid ? logic'(head.ev.kind) : 1'b0;
  assign out_pc     = out_valid ? head.ev.pc : 32'd0;
  assign out_target = out_valid ? head.ev.target : 32'd0;
  assign out_depth  = out_valid ? head.depth : '0;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ftrace_buffer.sv
// Directed bench for ftrace_buffer (2 lanes, 4-entry FIFO) with hand-computed
// expected records, depths and drop counts.
module tb_ftrace_buffer;

  logic        clock;
  logic        reset;
  logic        trace_en;
  logic [1:0]  ret_valid;
  logic [63:0] ret_pc;
  logic [63:0] ret_nextpc;
  logic [63:0] ret_inst;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_target;
  logic [7:0]  out_depth;
  logic [15:0] drop_cnt;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  ftrace_buffer #(.NUM_CH(2), .DEPTH(4), .DEPTH_W(8), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .trace_en   (trace_en),
    .ret_valid  (ret_valid),
    .ret_pc     (ret_pc),
    .ret_nextpc (ret_nextpc),
    .ret_inst   (ret_inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_pc     (out_pc),
    .out_target (out_target),
    .out_depth  (out_depth),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic kind, input logic [31:0] pc,
                      input logic [7:0] depth);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_kind"},  64'(out_kind),  64'(kind));
    chk({tag, "_pc"},    64'(out_pc),    64'(pc));
    chk({tag, "_depth"}, 64'(out_depth), 64'(depth));
  endtask

  task automatic lane(input int l, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] npc);
    ret_valid[l]          = 1'b1;
    ret_inst[l*32 +: 32]   = inst;
    ret_pc[l*32 +: 32]     = pc;
    ret_nextpc[l*32 +: 32] = npc;
  endtask

  task automatic idle();
    ret_valid = '0;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  localparam logic [31:0] I_CALL   = 32'h0000_00EF; // jal ra
  localparam logic [31:0] I_JAL0   = 32'h0000_006F; // jal x0
  localparam logic [31:0] I_RET    = 32'h0000_8067; // jalr x0, 0(ra)
  localparam logic [31:0] I_BOTH   = 32'h0000_82E7; // jalr t0, 0(ra)

  initial begin
    reset = 1'b0; trace_en = 1'b0; out_ready = 1'b0;
    ret_valid = '0; ret_pc = '0; ret_nextpc = '0; ret_inst = '0;
    repeat (2) tick();
    chk("rst_valid",  64'(out_valid),  64'd0);
    chk("rst_kind",   64'(out_kind),   64'd0);
    chk("rst_pc",     64'(out_pc),     64'd0);
    chk("rst_target", 64'(out_target), 64'd0);
    chk("rst_depth",  64'(out_depth),  64'd0);
    chk("rst_drop",   64'(drop_cnt),   64'd0);
    chk("rst_ovf",    64'(overflow),   64'd0);
    reset = 1'b1; trace_en = 1'b1;
    tick();

    // Single call held under back-pressure, then popped.
    lane(0, I_CALL, 32'h8000_0000, 32'h8000_0100); tick(); idle();
    head("single", 1'b0, 32'h8000_0000, 8'd0);
    chk("single_target", 64'(out_target), 64'h8000_0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      head("hold", 1'b0, 32'h8000_0000, 8'd0);
      chk("hold_target", 64'(out_target), 64'h8000_0100);
    end
    out_ready = 1'b1; tick();
    chk("single_pop", 64'(out_valid), 64'd0);
    lane(0, I_RET, 32'h8000_0200, 32'h8000_0004); tick(); idle();
    head("single_ret", 1'b1, 32'h8000_0200, 8'd0);
    tick();
    chk("single_ret_pop", 64'(out_valid), 64'd0);

    // Nesting: three calls then three returns.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lane(0, I_CALL, 32'h100 + 32'(4*k), 32'h1000); tick();
    end
    idle(); out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      head("nest_call", 1'b0, 32'h100 + 32'(4*k), 8'(k)); tick();
    end
    chk("nest_call_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lane(0, I_RET, 32'h200 + 32'(4*k), 32'h2000); tick();
    end
    idle(); out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      head("nest_ret", 1'b1, 32'h200 + 32'(4*k), 8'(2 - k)); tick();
    end
    chk("nest_ret_empty", 64'(out_valid), 64'd0);

    // Lane 0 call and lane 1 return in one cycle.
    out_ready = 1'b0;
    lane(0, I_CALL, 32'h300, 32'h400);
    lane(1, I_RET,  32'h304, 32'h308);
    tick(); idle(); out_ready = 1'b1;
    head("lane0", 1'b0, 32'h300, 8'd0); tick();
    head("lane1", 1'b1, 32'h304, 8'd0); tick();
    chk("lanes_empty", 64'(out_valid), 64'd0);

    // Overflow: six calls into four entries.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lane(0, I_CALL, 32'h500 + 32'(8*k), 32'h5000);
      lane(1, I_CALL, 32'h504 + 32'(8*k), 32'h5000);
      tick();
    end
    idle();
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    head("ovf_head", 1'b0, 32'h500, 8'd0);

    // Full FIFO with simultaneous pop and push.
    out_ready = 1'b1;
    lane(0, I_CALL, 32'h600, 32'h700); tick(); idle();
    head("full_d1", 1'b0, 32'h504, 8'd1);
    chk("full_drop", 64'(drop_cnt), 64'd2);
    tick(); head("full_d2", 1'b0, 32'h508, 8'd2);
    tick(); head("full_d3", 1'b0, 32'h50C, 8'd3);
    tick(); head("full_new", 1'b0, 32'h600, 8'd6);
    tick(); chk("full_empty", 64'(out_valid), 64'd0);
    lane(0, I_RET, 32'h610, 32'h620); tick(); idle();
    head("ovf_depth", 1'b1, 32'h610, 8'd6);
    tick(); chk("ovf_depth_pop", 64'(out_valid), 64'd0);

    // Filtering: non-link JAL and trace disabled.
    lane(0, I_JAL0, 32'h700, 32'h800); tick(); idle();
    chk("filt_jal0", 64'(out_valid), 64'd0);
    trace_en = 1'b0;
    lane(0, I_CALL, 32'h710, 32'h800); tick(); idle();
    chk("filt_dis", 64'(out_valid), 64'd0);
    trace_en = 1'b1;
    lane(0, I_CALL, 32'h720, 32'h800); tick(); idle();
    head("filt_depth", 1'b0, 32'h720, 8'd6);
    tick();

    // Drain continues while disabled; reset mid-drain.
    out_ready = 1'b0;
    lane(0, I_CALL, 32'h730, 32'h800);
    lane(1, I_CALL, 32'h734, 32'h800);
    tick(); idle();
    trace_en = 1'b0; out_ready = 1'b1;
    tick();
    head("dis_drain", 1'b0, 32'h734, 8'd8);
    #2 reset = 1'b0;
    #1;
    chk("mid_valid",  64'(out_valid),  64'd0);
    chk("mid_kind",   64'(out_kind),   64'd0);
    chk("mid_pc",     64'(out_pc),     64'd0);
    chk("mid_target", 64'(out_target), 64'd0);
    chk("mid_depth",  64'(out_depth),  64'd0);
    chk("mid_drop",   64'(drop_cnt),   64'd0);
    chk("mid_ovf",    64'(overflow),   64'd0);
    tick();
    reset = 1'b1; trace_en = 1'b1;
    lane(0, I_BOTH, 32'h900, 32'h904); tick(); idle();
    head("post_rst", 1'b0, 32'h900, 8'd0);
    tick();
    chk("post_rst_pop", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
